// File: rtl/canny_pkg.sv
// Shared Canny pipeline definitions: pixel widths, direction codes, the
// {dir, mag} pixel payload, NMS FSM state encoding and the keep compare.
package canny_pkg;

    localparam int unsigned MAG_W = 24;
    localparam int unsigned DIR_W = 2;
    localparam int unsigned PIX_W = DIR_W + MAG_W;

    typedef logic [DIR_W-1:0] dir_t;
    typedef logic [MAG_W-1:0] mag_t;

    // Quantised gradient direction; the name gives the compare axis partner.
    localparam dir_t DIR_N  = DIR_W'(0);   // up / down
    localparam dir_t DIR_E  = DIR_W'(1);   // left / right
    localparam dir_t DIR_NW = DIR_W'(2);   // up-left / down-right
    localparam dir_t DIR_NE = DIR_W'(3);   // up-right / down-left

    typedef struct packed {
        dir_t dir;
        mag_t mag;
    } pix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } nms_state_e;

    // Strict against the raster-earlier neighbour, non-strict against the later
    // one, so a plateau of two equal pixels keeps exactly the first.
    function automatic logic nms_keep(input mag_t ctr, input mag_t prev, input mag_t next);
        return (ctr > prev) && (ctr >= next);
    endfunction

endpackage

// File: rtl/nms_suppress_if.sv
// Stream interface of the NMS stage.
//   start      frame-start pulse
//   in_valid   input beat qualifier, in_data {dir, mag}
//   out_valid  output beat qualifier, out_data {dir, kept mag}
//   busy       frame in progress, frame_done end-of-frame pulse
// master = upstream/downstream environment, slave = the NMS block.
interface nms_suppress_if;
    import canny_pkg::*;

    logic start;
    logic in_valid;
    pix_t in_data;
    logic out_valid;
    pix_t out_data;
    logic busy;
    logic frame_done;

    modport master (
        output start, in_valid, in_data,
        input  out_valid, out_data, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output out_valid, out_data, busy, frame_done
    );

endinterface

// File: rtl/nms_line_buffer.sv
// Enable-gated delay line of N entries: each enabled cycle returns the word
// written N enables earlier and stores the new one in its place.
//   clk, rst   clock, synchronous active-high reset (pointer only)
//   en_i       advance the line by one word
//   din_i      word written on en_i
//   dout_c_o   word written N enables ago (combinational RAM read)
module nms_line_buffer
    import canny_pkg::*;
#(
    parameter int unsigned N  = 512,
    parameter int unsigned DW = PIX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_c_o
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] mem_q [N];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Read-before-write at the same address gives the N-deep delay.
    assign dout_c_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == AW'(N - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately not cleared; stale words only reach border centres.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/nms_suppress.sv
// Canny non-maximum suppression over a raster stream of {dir, mag} words.
// Two line buffers feed a 3x3 magnitude window; the centre is kept only if it
// is a maximum along its quantised gradient direction. After the last input
// pixel the block flushes WIDTH+1 zero beats to drain the bottom row.
//   clk, rst   clock, synchronous active-high reset
//   bus        slave side of nms_suppress_if (start, in_*, out_*, busy, frame_done)
module nms_suppress
    import canny_pkg::*;
#(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 638
) (
    input  logic           clk,
    input  logic           rst,
    nms_suppress_if.slave  bus
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = $clog2(DEPTH + 2);

    nms_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic beat_c;
    logic flush_c;
    logic last_real_c;
    logic last_flush_c;

    // Flush beats continue the raster count: the final one lands on (DEPTH+1, 0).
    assign last_real_c  = (row_q == ROW_W'(DEPTH - 1)) && (col_q == COL_W'(WIDTH - 1));
    assign last_flush_c = (row_q == ROW_W'(DEPTH + 1)) && (col_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (bus.in_valid && last_real_c) state_d = ST_FLUSH;
            ST_FLUSH: if (last_flush_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: which cycles advance the window, and whether data is forced to zero.
    always_comb begin
        beat_c  = 1'b0;
        flush_c = 1'b0;
        case (state_q)
            ST_RUN:   beat_c = bus.in_valid;
            ST_FLUSH: begin
                beat_c  = 1'b1;
                flush_c = 1'b1;
            end
            default:  ;
        endcase
    end

    // Raster position of the current beat; held at zero while idle.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == ST_IDLE) begin
            col_d = '0;
            row_d = '0;
        end else if (beat_c) begin
            if (col_q == COL_W'(WIDTH - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    pix_t beat_pix;
    pix_t lb0_out;
    pix_t lb1_out;

    assign beat_pix = flush_c ? '0 : bus.in_data;

    nms_line_buffer #(.N(WIDTH), .DW(PIX_W)) u_lb_mid (
        .clk      (clk),
        .rst      (rst),
        .en_i     (beat_c),
        .din_i    (beat_pix),
        .dout_c_o (lb0_out)
    );

    nms_line_buffer #(.N(WIDTH), .DW(PIX_W)) u_lb_top (
        .clk      (clk),
        .rst      (rst),
        .en_i     (beat_c),
        .din_i    (lb0_out),
        .dout_c_o (lb1_out)
    );

    // The beat at raster index k completes the window centred on k-WIDTH-1.
    logic             ctr_ok_c;
    logic             ctr_border_c;
    logic [COL_W-1:0] ctr_col_c;
    logic [ROW_W-1:0] ctr_row_c;

    always_comb begin
        ctr_ok_c = (row_q >= ROW_W'(2)) || ((row_q == ROW_W'(1)) && (col_q != '0));
        if (col_q != '0) begin
            ctr_col_c = col_q - COL_W'(1);
            ctr_row_c = row_q - ROW_W'(1);
        end else begin
            ctr_col_c = COL_W'(WIDTH - 1);
            ctr_row_c = row_q - ROW_W'(2);
        end
        ctr_border_c = (ctr_row_c == '0) || (ctr_row_c == ROW_W'(DEPTH - 1)) ||
                       (ctr_col_c == '0) || (ctr_col_c == COL_W'(WIDTH - 1));
    end

    // 3x3 window: [row][col], row 0 = top, col 2 = newest column.
    mag_t win_q [3][3];
    dir_t dir_r_q;
    dir_t dir_c_q;
    logic win_vld_q;
    logic win_border_q;
    logic win_last_q;

    always_ff @(posedge clk) begin
        if (beat_c) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_out.mag;
            win_q[1][2] <= lb0_out.mag;
            win_q[2][2] <= beat_pix.mag;
            dir_r_q     <= lb0_out.dir;
            dir_c_q     <= dir_r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld_q    <= 1'b0;
            win_border_q <= 1'b0;
            win_last_q   <= 1'b0;
        end else begin
            win_vld_q    <= beat_c && ctr_ok_c;
            win_border_q <= ctr_border_c;
            win_last_q   <= flush_c && last_flush_c;
        end
    end

    // Neighbour selection along the gradient; prev is the raster-earlier one.
    mag_t prev_c;
    mag_t next_c;
    pix_t out_data_d;

    always_comb begin
        prev_c = win_q[1][0];
        next_c = win_q[1][2];
        case (dir_c_q)
            DIR_N: begin
                prev_c = win_q[0][1];
                next_c = win_q[2][1];
            end
            DIR_E: begin
                prev_c = win_q[1][0];
                next_c = win_q[1][2];
            end
            DIR_NW: begin
                prev_c = win_q[0][0];
                next_c = win_q[2][2];
            end
            default: begin
                prev_c = win_q[0][2];
                next_c = win_q[2][0];
            end
        endcase

        out_data_d = '0;
        if (win_vld_q && !win_border_q) begin
            out_data_d.dir = dir_c_q;
            out_data_d.mag = nms_keep(win_q[1][1], prev_c, next_c) ? win_q[1][1] : '0;
        end
    end

    logic out_valid_q;
    pix_t out_data_q;
    logic busy_q;
    logic frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= win_vld_q;
            out_data_q   <= out_data_d;
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= win_last_q;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule
